bringup_sequencer: RTL and testbench

Sequences the upscaler's power-up and recovery on the 50 MHz crystal clock. It gates PLL lock, releases the HDMI, audio and capture resets in a fixed order, and qualifies the composite input by timing analog field edges. It drives the video source select (live video vs. colour-bar fallback) and re-acquires the input after signal loss or a PLL drop. It replaces the ad-hoc reset counter in the top level; its reset outputs feed each domain's existing double-flop reset synchronizers.

---
 rtl/upscaler_pkg.sv | 24 ++
 rtl/bringup_sequencer_field_monitor.sv | 52 +++++
 rtl/bringup_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_bringup_sequencer.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/upscaler_pkg.sv
// Shared types and NTSC timing constants for the upscaler control logic.
package upscaler_pkg;

  typedef enum logic [2:0] {
    RESET,
    PLL_WAIT,
    SETTLE,
    AUD_DELAY,
    ACQUIRE,
    LOCKED,
    NOSIGNAL
  } bringup_state_t;

  // Field period in 50 MHz cycles; the window brackets NTSC with margin.
  localparam int unsigned FIELD_NOM_CYC_50M = 834_168;
  localparam int unsigned FIELD_MIN_CYC_DEF = 750_000;
  localparam int unsigned FIELD_MAX_CYC_DEF = 920_000;
  localparam int unsigned FIELD_CNT_W       = 20;

  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/bringup_sequencer_field_monitor.sv
// Synchronizes the per-field vsync toggle, detects field edges and times the
// interval between them against the valid field window.
module field_monitor
  import upscaler_pkg::*;
#(
  parameter int unsigned FIELD_MIN_CYC = FIELD_MIN_CYC_DEF,
  parameter int unsigned FIELD_MAX_CYC = FIELD_MAX_CYC_DEF
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic vsync_toggle_i,
  input  logic restart_i,
  output logic field_edge_o,
  output logic interval_valid_o,
  output logic interval_timeout_o
);

  localparam logic [FIELD_CNT_W-1:0] MIN_VAL = FIELD_CNT_W'(FIELD_MIN_CYC);
  localparam logic [FIELD_CNT_W-1:0] MAX_VAL = FIELD_CNT_W'(FIELD_MAX_CYC);
  localparam logic [FIELD_CNT_W-1:0] SAT_VAL = FIELD_CNT_W'(FIELD_MAX_CYC + 1);

  // [0],[1] form the synchronizer; [2] is the delayed copy for edge detect.
  logic [2:0]             vs_q;
  logic [FIELD_CNT_W-1:0] cnt_q, cnt_d;
  logic                   edge_w;

  assign edge_w = vs_q[1] ^ vs_q[2];

  always_comb begin
    cnt_d = cnt_q;
    if (edge_w || restart_i) begin
      cnt_d = '0;
    end else if (cnt_q != SAT_VAL) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      vs_q  <= '0;
      cnt_q <= '0;
    end else begin
      vs_q  <= {vs_q[1:0], vsync_toggle_i};
      cnt_q <= cnt_d;
    end
  end

  assign field_edge_o       = edge_w;
  assign interval_valid_o   = edge_w && (cnt_q >= MIN_VAL) && (cnt_q <= MAX_VAL);
  assign interval_timeout_o = (cnt_q == SAT_VAL);

endmodule

// File: rtl/bringup_sequencer.sv
// Power-up and recovery sequencer: gates PLL lock, releases the HDMI, audio
// and capture resets in order, qualifies the composite input, picks the source.
module bringup_sequencer
  import upscaler_pkg::*;
#(
  parameter int unsigned PLL_SETTLE_CYC   = 16_777_215,
  parameter int unsigned AUDIO_DELAY_CYC  = 1024,
  parameter int unsigned SYNC_TIMEOUT_CYC = 5_000_000,
  parameter int unsigned FIELD_MIN_CYC    = FIELD_MIN_CYC_DEF,
  parameter int unsigned FIELD_MAX_CYC    = FIELD_MAX_CYC_DEF,
  parameter int unsigned LOCK_FIELDS      = 4,
  parameter int unsigned MISS_LIMIT       = 3,
  parameter int unsigned CAP_RST_CYC      = 16
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       pll_locked,
  input  logic       vsync_toggle,
  input  logic       force_pattern,
  output logic       hdmi_rst,
  output logic       audio_rst,
  output logic       capture_rst,
  output logic       pattern_sel,
  output logic       video_locked,
  output logic [2:0] state
);

  localparam int unsigned DLY_MAX = (PLL_SETTLE_CYC > AUDIO_DELAY_CYC) ?
                                    PLL_SETTLE_CYC : AUDIO_DELAY_CYC;
  localparam int unsigned DLY_W   = cnt_width(DLY_MAX);
  localparam int unsigned TMO_W   = cnt_width(SYNC_TIMEOUT_CYC);
  localparam int unsigned VCNT_W  = cnt_width(LOCK_FIELDS);
  localparam int unsigned MISS_W  = cnt_width(MISS_LIMIT);
  localparam int unsigned CAP_W   = cnt_width(CAP_RST_CYC);

  localparam logic [DLY_W-1:0]  SETTLE_LAST = DLY_W'(PLL_SETTLE_CYC - 1);
  localparam logic [DLY_W-1:0]  AUDIO_LAST  = DLY_W'(AUDIO_DELAY_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(SYNC_TIMEOUT_CYC - 1);
  localparam logic [VCNT_W-1:0] LOCK_N      = VCNT_W'(LOCK_FIELDS);
  localparam logic [MISS_W-1:0] MISS_N      = MISS_W'(MISS_LIMIT);
  localparam logic [CAP_W-1:0]  CAP_N       = CAP_W'(CAP_RST_CYC);

  logic [1:0]        pll_q;
  logic              pll_sync;
  bringup_state_t    state_q, state_d;
  logic [DLY_W-1:0]  dly_q, dly_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [VCNT_W-1:0] valid_cnt_q, valid_cnt_d;
  logic [MISS_W-1:0] miss_q, miss_d;
  logic              first_q, first_d;
  logic [CAP_W-1:0]  cap_cnt_q, cap_cnt_d;
  logic              hdmi_rst_q, hdmi_rst_d;
  logic              audio_rst_q, audio_rst_d;
  logic              capture_rst_q, capture_rst_d;
  logic              pattern_sel_q, pattern_sel_d;
  logic              video_locked_q, video_locked_d;

  logic field_edge, interval_valid, interval_timeout, fm_restart;

  assign pll_sync = pll_q[1];

  field_monitor #(
    .FIELD_MIN_CYC (FIELD_MIN_CYC),
    .FIELD_MAX_CYC (FIELD_MAX_CYC)
  ) u_field_monitor (
    .sys_clk            (sys_clk),
    .sys_rst            (sys_rst),
    .vsync_toggle_i     (vsync_toggle),
    .restart_i          (fm_restart),
    .field_edge_o       (field_edge),
    .interval_valid_o   (interval_valid),
    .interval_timeout_o (interval_timeout)
  );

  always_comb begin
    state_d     = state_q;
    dly_d       = dly_q;
    tmo_d       = tmo_q;
    valid_cnt_d = valid_cnt_q;
    miss_d      = miss_q;
    first_d     = first_q;
    cap_cnt_d   = (cap_cnt_q != '0) ? cap_cnt_q - 1'b1 : '0;
    fm_restart  = 1'b0;

    unique case (state_q)
      RESET: state_d = PLL_WAIT;

      PLL_WAIT: begin
        if (pll_sync) begin
          dly_d   = '0;
          state_d = SETTLE;
        end
      end

      SETTLE: begin
        if (dly_q == SETTLE_LAST) begin
          dly_d   = '0;
          state_d = AUD_DELAY;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      AUD_DELAY: begin
        if (dly_q == AUDIO_LAST) begin
          tmo_d       = '0;
          valid_cnt_d = '0;
          first_d     = 1'b1;
          state_d     = ACQUIRE;
        end else begin
          dly_d = dly_q + 1'b1;
        end
      end

      ACQUIRE: begin
        tmo_d = tmo_q + 1'b1;
        // The first edge only opens the timing window; later edges are judged.
        if (field_edge) begin
          if (first_q) begin
            first_d = 1'b0;
          end else if (interval_valid) begin
            valid_cnt_d = valid_cnt_q + 1'b1;
          end else begin
            valid_cnt_d = '0;
          end
        end
        if (valid_cnt_d == LOCK_N) begin
          miss_d  = '0;
          state_d = LOCKED;
        end else if (tmo_q == TMO_LAST) begin
          state_d = NOSIGNAL;
        end
      end

      LOCKED: begin
        if (field_edge) begin
          miss_d = interval_valid ? '0 : miss_q + 1'b1;
        end else if (interval_timeout) begin
          miss_d     = miss_q + 1'b1;
          fm_restart = 1'b1;
        end
        if (miss_d == MISS_N) begin
          cap_cnt_d   = CAP_N;
          tmo_d       = '0;
          valid_cnt_d = '0;
          first_d     = 1'b1;
          state_d     = ACQUIRE;
        end
      end

      NOSIGNAL: begin
        if (field_edge) begin
          tmo_d       = '0;
          valid_cnt_d = '0;
          first_d     = 1'b1;
          state_d     = ACQUIRE;
        end
      end

      default: state_d = RESET;
    endcase

    // Losing PLL lock overrides everything and restarts the whole sequence.
    if (!pll_sync && (state_q != RESET) && (state_q != PLL_WAIT)) begin
      cap_cnt_d = '0;
      state_d   = PLL_WAIT;
    end

    hdmi_rst_d     = (state_d == RESET) || (state_d == PLL_WAIT) || (state_d == SETTLE);
    audio_rst_d    = hdmi_rst_d || (state_d == AUD_DELAY);
    capture_rst_d  = audio_rst_d || (cap_cnt_d != '0);
    video_locked_d = (state_d == LOCKED);
    pattern_sel_d  = !(video_locked_d && !force_pattern);
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pll_q          <= '0;
      state_q        <= RESET;
      dly_q          <= '0;
      tmo_q          <= '0;
      valid_cnt_q    <= '0;
      miss_q         <= '0;
      first_q        <= 1'b1;
      cap_cnt_q      <= '0;
      hdmi_rst_q     <= 1'b1;
      audio_rst_q    <= 1'b1;
      capture_rst_q  <= 1'b1;
      pattern_sel_q  <= 1'b1;
      video_locked_q <= 1'b0;
    end else begin
      pll_q          <= {pll_q[0], pll_locked};
      state_q        <= state_d;
      dly_q          <= dly_d;
      tmo_q          <= tmo_d;
      valid_cnt_q    <= valid_cnt_d;
      miss_q         <= miss_d;
      first_q        <= first_d;
      cap_cnt_q      <= cap_cnt_d;
      hdmi_rst_q     <= hdmi_rst_d;
      audio_rst_q    <= audio_rst_d;
      capture_rst_q  <= capture_rst_d;
      pattern_sel_q  <= pattern_sel_d;
      video_locked_q <= video_locked_d;
    end
  end

  assign hdmi_rst     = hdmi_rst_q;
  assign audio_rst    = audio_rst_q;
  assign capture_rst  = capture_rst_q;
  assign pattern_sel  = pattern_sel_q;
  assign video_locked = video_locked_q;
  assign state        = state_q;

endmodule

// File: tb/tb_bringup_sequencer.sv
// Directed bench for bringup_sequencer with shortened timing parameters;
// expected cycle counts are worked out by hand from the sequencing rules.
module tb_bringup_sequencer;

  logic       sys_clk;
  logic       sys_rst;
  logic       pll_locked;
  logic       vsync_toggle;
  logic       force_pattern;
  logic       hdmi_rst;
  logic       audio_rst;
  logic       capture_rst;
  logic       pattern_sel;
  logic       video_locked;
  logic [2:0] state;

  int n_cmp   = 0;
  int n_bad   = 0;
  int period  = 0;
  int tog_cnt = 0;
  int toggles = 0;

  bringup_sequencer #(
    .PLL_SETTLE_CYC   (100),
    .AUDIO_DELAY_CYC  (10),
    .SYNC_TIMEOUT_CYC (1000),
    .FIELD_MIN_CYC    (80),
    .FIELD_MAX_CYC    (120),
    .LOCK_FIELDS      (4),
    .MISS_LIMIT       (3),
    .CAP_RST_CYC      (16)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pll_locked    (pll_locked),
    .vsync_toggle  (vsync_toggle),
    .force_pattern (force_pattern),
    .hdmi_rst      (hdmi_rst),
    .audio_rst     (audio_rst),
    .capture_rst   (capture_rst),
    .pattern_sel   (pattern_sel),
    .video_locked  (video_locked),
    .state         (state)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  // One sys_clk cycle; toggles vsync every 'period' cycles when period != 0.
  task automatic step();
    @(negedge sys_clk);
    if (period != 0) begin
      tog_cnt++;
      if (tog_cnt >= period) begin
        vsync_toggle = ~vsync_toggle;
        tog_cnt      = 0;
        toggles++;
      end
    end
  endtask

  task automatic set_period(input int p);
    period  = p;
    tog_cnt = 0;
  endtask

  initial begin
    int n;
    int saw;
    int t0;
    sys_rst       = 1'b1;
    pll_locked    = 1'b0;
    vsync_toggle  = 1'b0;
    force_pattern = 1'b0;
    repeat (3) @(negedge sys_clk);

    chk("rst_hdmi",    int'(hdmi_rst),     1);
    chk("rst_audio",   int'(audio_rst),    1);
    chk("rst_capture", int'(capture_rst),  1);
    chk("rst_pattern", int'(pattern_sel),  1);
    chk("rst_vlock",   int'(video_locked), 0);
    chk("rst_state",   int'(state),        0);

    // Power-up: PLL locks 5 cycles after reset release.
    sys_rst = 1'b0;
    repeat (5) step();
    chk("pll_wait_state", int'(state), 1);
    pll_locked = 1'b1;
    n = 0;
    while (hdmi_rst && n < 400) begin step(); n++; end
    chk("hdmi_rel_cyc", n, 103);
    chk("audio_held_at_hdmi", int'(audio_rst), 1);
    chk("cap_held_at_hdmi", int'(capture_rst), 1);
    n = 0;
    while (audio_rst && n < 50) begin step(); n++; end
    chk("audio_rel_cyc", n, 10);
    chk("cap_rel_with_audio", int'(capture_rst), 0);
    chk("acquire_state", int'(state), 4);

    // Too-short fields never qualify; window expires into NOSIGNAL.
    set_period(60);
    saw = 0;
    n = 0;
    while (state != 3'd6 && n < 1500) begin
      step();
      n++;
      if (video_locked) saw = 1;
    end
    chk("nosignal_cyc", n, 1000);
    chk("no_lock_short_fields", saw, 0);

    // Nominal fields: edge 1 re-enters ACQUIRE, edge 2 opens timing, 3..6 valid.
    set_period(100);
    toggles = 0;
    n = 0;
    while (!video_locked && n < 2000) begin step(); n++; end
    chk("lock_after_edges", toggles, 6);
    chk("locked_state", int'(state), 5);
    chk("locked_live_video", int'(pattern_sel), 0);

    force_pattern = 1'b1;
    step();
    chk("force_pattern_sel", int'(pattern_sel), 1);
    chk("force_vlock_kept", int'(video_locked), 1);
    force_pattern = 1'b0;
    step();
    chk("unforce_pattern_sel", int'(pattern_sel), 0);

    // Signal loss: stop immediately after a toggle, then count to re-acquire.
    t0 = toggles;
    n = 0;
    while (toggles == t0 && n < 200) begin step(); n++; end
    set_period(0);
    n = 0;
    while (!capture_rst && n < 1000) begin step(); n++; end
    chk("loss_cyc", n, 369);
    chk("loss_state", int'(state), 4);
    chk("loss_pattern", int'(pattern_sel), 1);
    chk("loss_vlock", int'(video_locked), 0);
    n = 0;
    while (capture_rst && n < 100) begin step(); n++; end
    chk("cap_pulse_width", n, 16);

    set_period(100);
    n = 0;
    while (!video_locked && n < 2000) begin step(); n++; end
    chk("relock_after_loss", int'(video_locked), 1);

    // PLL drop while LOCKED.
    set_period(0);
    pll_locked = 1'b0;
    n = 0;
    while (!(hdmi_rst && audio_rst && capture_rst) && n < 20) begin step(); n++; end
    chk("pll_drop_within_3", int'(n <= 3), 1);
    repeat (47) step();
    chk("pll_drop_state", int'(state), 1);
    chk("pll_drop_vlock", int'(video_locked), 0);
    chk("pll_drop_pattern", int'(pattern_sel), 1);

    pll_locked = 1'b1;
    n = 0;
    while (hdmi_rst && n < 400) begin step(); n++; end
    chk("reseq_hdmi_cyc", n, 103);
    n = 0;
    while (audio_rst && n < 50) begin step(); n++; end
    chk("reseq_audio_cyc", n, 10);
    chk("reseq_state", int'(state), 4);

    // Asynchronous reset between clock edges.
    sys_rst = 1'b1;
    #1;
    chk("async_rst_hdmi", int'(hdmi_rst), 1);
    chk("async_rst_state", int'(state), 0);
    chk("async_rst_capture", int'(capture_rst), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
